freq_meter: RTL and testbench

- Measures the frequency of a slow external square wave (LED drive, button, test-point) in the clk_50M domain.
- Counts rising edges of an asynchronous input over a fixed gate window (default 1 s) and publishes the count once per window.
- Input-side counterpart to the team's clock-divider/blinker blocks: those generate a slow toggle, this block reads one back and reports its rate.
- Window is back-to-back: no dead time between windows while enabled.

---
 rtl/freq_meter.sv | 161 ++++++++++++++++
 tb/tb_freq_meter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of a slow asynchronous input over a fixed,
// back-to-back gate window in the clk_50M domain and publishes one count per
// window. The count saturates and raises ovf instead of wrapping.

module freq_meter #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int GATE_CYCLES = 50_000_000,
  parameter int CNT_W       = 28
) (
  input  logic             clk_50M,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_out,
  output logic             valid,
  output logic             ovf,
  output logic             busy
);

  // A window shorter than the arm/flush sequence makes no sense, and a zero
  // clock rate means the default gate length was derived from nothing.
  if (GATE_CYCLES < 4 || CLK_HZ < 1) begin : g_param_check
    $error("freq_meter: GATE_CYCLES must be >= 4 and CLK_HZ must be positive");
  end

  localparam int                GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]     GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2
  } state_t;

  state_t state, state_next;

  // Input synchronizer and edge history
  logic s1, s2, s3;
  logic rise_pulse;

  // Window bookkeeping
  logic             arm_cnt;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             window_ovf;

  // Combinational helpers
  logic             terminal;
  logic             at_max;
  logic             count_step;
  logic             ovf_hit;
  logic [CNT_W-1:0] edge_cnt_upd;
  logic             window_ovf_upd;
  logic             window_run;

  // Two-flop synchronizer followed by a history flop for edge detection.
  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // flops sample their inputs from the same pre-edge values; blocking
  // assignments here would collapse s1/s2/s3 into a single flop.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_pulse = s2 & ~s3;

  // State register.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> ARM (2 cycles) -> GATE, any state falls back to
  // IDLE when en drops.
  // NOTE: state_next gets its default before the case statement so every path
  // assigns it; a missing branch would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (en) state_next = ARM;
      end
      ARM: begin
        if (!en)         state_next = IDLE;
        else if (arm_cnt) state_next = GATE;
      end
      GATE: begin
        if (!en) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The closing cycle of a window; an edge here still belongs to it.
  assign terminal       = (state == GATE) && (gate_cnt == GATE_LAST);
  assign at_max         = (edge_cnt == CNT_MAX);
  assign count_step     = rise_pulse & ~at_max;
  assign ovf_hit        = rise_pulse & at_max;
  assign edge_cnt_upd   = edge_cnt + CNT_W'(count_step);
  assign window_ovf_upd = window_ovf | ovf_hit;

  // Keep accumulating only while a window stays open; entering GATE, closing
  // a window and aborting all start from a clean slate.
  assign window_run = (state == GATE) && (state_next == GATE) && !terminal;

  // ARM dwell counter: 0 on the first ARM cycle, 1 on the second.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      arm_cnt <= 1'b0;
    end else begin
      arm_cnt <= (state == ARM) && (state_next == ARM);
    end
  end

  // Gate timer, saturating edge counter and sticky window overflow.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      window_ovf <= 1'b0;
    end else if (window_run) begin
      gate_cnt   <= gate_cnt + GW'(1);
      edge_cnt   <= edge_cnt_upd;
      window_ovf <= window_ovf_upd;
    end else begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      window_ovf <= 1'b0;
    end
  end

  // Registered outputs: publish on the cycle after the terminal cycle, even
  // if en dropped on that terminal cycle; otherwise hold the last result.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      freq_out <= '0;
      ovf      <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      valid <= terminal;
      busy  <= (state_next == GATE);
      if (terminal) begin
        freq_out <= edge_cnt_upd;
        ovf      <= window_ovf_upd;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed stimulus with a scoreboard. Stimulus pushes the
// hand-computed result of every window it expects; a monitor pops and
// compares whenever the DUT raises valid.

module tb_freq_meter;

  localparam int GATE  = 100;
  localparam int CNT_W = 4;

  logic             clk_50M;
  logic             rst_n;
  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] freq_out;
  logic             valid;
  logic             ovf;
  logic             busy;

  freq_meter #(
    .CLK_HZ      (1000),
    .GATE_CYCLES (GATE),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_50M  (clk_50M),
    .rst_n    (rst_n),
    .en       (en),
    .sig_in   (sig_in),
    .freq_out (freq_out),
    .valid    (valid),
    .ovf      (ovf),
    .busy     (busy)
  );

  initial clk_50M = 1'b0;
  always #5 clk_50M = ~clk_50M;

  typedef struct {
    logic [31:0] freq;
    logic        ovf;
    logic        care_freq;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   period  = 10;   // 0: generator idle, stimulus drives sig_in directly
  int   ph      = 0;
  int   valid_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int f, input logic o, input logic c);
    exp_t e;
    e.freq      = f;
    e.ovf       = o;
    e.care_freq = c;
    sb_q.push_back(e);
  endtask

  // Count rising edges until valid is seen after an edge, bounded by budget.
  task automatic wait_valid(input string name, input int budget, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk_50M);
      #1;
      cycles++;
    end while (!valid && cycles < budget);
    if (!valid) check({name, "_timeout"}, {31'd0, valid}, 32'd1);
  endtask

  // Periodic square-wave generator, updated away from the clock edge.
  initial begin
    forever begin
      @(posedge clk_50M);
      #2;
      if (period != 0) begin
        if (ph >= period - 1) ph = 0;
        else                  ph++;
        sig_in = (ph < period / 2);
      end
    end
  end

  // Scoreboard monitor: sample on the falling edge whenever valid is high.
  always @(negedge clk_50M) begin
    exp_t e;
    if (rst_n && valid) begin
      valid_seen++;
      if (sb_q.size() == 0) begin
        check("unexpected_valid", {31'd0, valid}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        if (e.care_freq) check("sb_freq_out", {28'd0, freq_out}, e.freq);
        check("sb_ovf", {31'd0, ovf}, {31'd0, e.ovf});
      end
    end
  end

  initial begin
    int cyc;
    int seen0;

    rst_n  = 1'b0;
    en     = 1'b0;
    sig_in = 1'b0;
    #1;
    check("rst_freq_out", {28'd0, freq_out}, 32'd0);
    check("rst_valid",    {31'd0, valid},    32'd0);
    check("rst_ovf",      {31'd0, ovf},      32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    repeat (3) @(posedge clk_50M);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk_50M);
    #1;

    // Nominal: period 10 -> exactly 10 edges per 100-cycle window.
    en = 1'b1;
    repeat (3) push_exp(10, 1'b0, 1'b1);
    wait_valid("nom_first", 300, cyc);
    check("nom_first_latency", cyc, 32'd103);
    check("nom_busy", {31'd0, busy}, 32'd1);
    wait_valid("nom_second", 300, cyc);
    check("nom_interval_1", cyc, 32'd100);
    wait_valid("nom_third", 300, cyc);
    check("nom_interval_2", cyc, 32'd100);

    // Enable abort at gate_cnt = 60.
    repeat (60) @(posedge clk_50M);
    #1 en = 1'b0;
    @(posedge clk_50M);
    #1;
    check("abort_busy",     {31'd0, busy},     32'd0);
    check("abort_valid",    {31'd0, valid},    32'd0);
    check("abort_freq_out", {28'd0, freq_out}, 32'd10);
    seen0 = valid_seen;
    repeat (150) @(posedge clk_50M);
    #1;
    check("abort_no_valid", valid_seen - seen0, 32'd0);
    check("abort_hold_freq", {28'd0, freq_out}, 32'd10);
    en = 1'b1;
    push_exp(10, 1'b0, 1'b1);
    wait_valid("reen", 300, cyc);
    check("reen_latency", cyc, 32'd103);

    // Static input: sig_in held high. First window is a transition window.
    period = 0;
    sig_in = 1'b1;
    push_exp(0, 1'b0, 1'b0);
    repeat (3) push_exp(0, 1'b0, 1'b1);
    for (int w = 0; w < 4; w++) begin
      wait_valid("static", 300, cyc);
      check("static_interval", cyc, 32'd100);
    end

    // Boundary: a pulse on gate_cnt 99 of W1 and one on gate_cnt 0 of W3.
    // sig_in rising after edge k gives an edge pulse in gate cycle k+2.
    push_exp(2, 1'b0, 1'b1);
    push_exp(1, 1'b0, 1'b1);
    push_exp(1, 1'b0, 1'b1);
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk_50M);
      #1;
      case (k)
        1, 50, 150, 170, 250: sig_in = 1'b0;
        5, 97, 160, 198:      sig_in = 1'b1;
        default: ;
      endcase
      if (k % 100 == 0) check("bnd_valid_timing", {31'd0, valid}, 32'd1);
    end

    // Saturation: period 4 -> 25 edges into a 4-bit counter.
    en     = 1'b0;
    period = 4;
    repeat (20) @(posedge clk_50M);
    #1 en = 1'b1;
    push_exp(15, 1'b1, 1'b1);
    wait_valid("sat", 300, cyc);
    check("sat_latency", cyc, 32'd103);
    period = 20;
    push_exp(0, 1'b0, 1'b0);
    push_exp(5, 1'b0, 1'b1);
    wait_valid("desat_mixed", 300, cyc);
    wait_valid("desat", 300, cyc);
    check("desat_interval", cyc, 32'd100);

    // Reset mid-window: publish 7, then reset at gate_cnt = 50.
    period = 0;
    sig_in = 1'b0;
    push_exp(0, 1'b0, 1'b0);
    push_exp(7, 1'b0, 1'b1);
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk_50M);
      #1;
      if (k >= 110 && k <= 175) begin
        if (k % 10 == 0) sig_in = 1'b1;
        if (k % 10 == 5) sig_in = 1'b0;
      end
    end
    check("pre_rst_valid", {31'd0, valid}, 32'd1);
    repeat (50) @(posedge clk_50M);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_freq_out", {28'd0, freq_out}, 32'd0);
    check("mid_rst_ovf",      {31'd0, ovf},      32'd0);
    check("mid_rst_valid",    {31'd0, valid},    32'd0);
    check("mid_rst_busy",     {31'd0, busy},     32'd0);
    check("mid_rst_sb_empty", sb_q.size(),       32'd0);
    repeat (5) @(posedge clk_50M);
    #1 rst_n = 1'b1;
    push_exp(0, 1'b0, 1'b1);
    wait_valid("post_rst", 300, cyc);
    check("post_rst_latency", cyc, 32'd103);

    repeat (5) @(posedge clk_50M);
    #1;
    check("final_sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
